result_queue_loader: RTL and testbench
======================================

// Module: result_queue_loader
//
// PURPOSE
// Producer-side stage of the result queue.
// Accepts narrow results (LANE_W bits) from the compute pipeline over a valid/ready handshake.
// Packs LANES of them, little-endian, into one WIDTH-bit queue word.
// Writes each word into the result FIFO, honouring its full flag.
// A result tagged res_last closes the current word early (zero-padded) and signals packet completion.
//
// PARAMETERS
// WIDTH   32  queue word width; must equal the result FIFO data width
// LANE_W   8  width of one incoming result
// LANES   WIDTH/LANE_W  results per queue word; WIDTH must be an exact multiple of LANE_W
//
// PORTS
// clk            in   1       clock, all logic on posedge
// resetn         in   1       asynchronous active-low reset
// res_valid      in   1       upstream result valid
// res_ready      out  1       block accepts a result this cycle
// res_data       in   LANE_W  result payload
// res_last       in   1       final result of a packet (qualified by res_valid & res_ready)
// rq_full        in   1       result FIFO full
// rq_we          out  1       result FIFO write enable (one-cycle pulse per word)
// rq_data        out  WIDTH   packed word presented to the FIFO
// packet_done    out  1       one-cycle pulse after the word holding res_last is written
// words_written  out  16      count of words written since reset; wraps
//
// BEHAVIOUR
// - Reset (resetn low, async): state S_Reset, lane index 0, accumulator 0, last-flag 0, words_written 0.
//   All outputs are 0 while in reset; res_ready is 0 during reset and in S_Reset.
// - States and transitions:
//   S_Reset -> S_Fill unconditionally, on the first clock after release.
//   S_Fill: res_ready=1. A handshake (res_valid & res_ready) stores res_data into acc[idx*LANE_W +: LANE_W].
//     If idx==LANES-1 or res_last: latch last-flag=res_last, go to S_Write.
//     Otherwise idx++ and stay in S_Fill. With no handshake, nothing changes.
//   S_Write: res_ready=0. rq_data=acc. rq_we = !rq_full (Moore output on state, gated combinationally by rq_full).
//     If !rq_full: words_written++, acc<=0, idx<=0; go to S_Done if last-flag, else S_Fill.
//     If rq_full: hold in S_Write with acc unchanged, for as many cycles as needed.
//   S_Done: packet_done=1 for exactly this cycle, clear last-flag, go to S_Fill. res_ready=0.
//   Any illegal encoding -> S_Reset.
// - Invariants:
//   rq_we is never 1 while rq_full is 1.
//   rq_data equals acc whenever rq_we=1.
//   Unfilled upper lanes are 0.
// - Latency: the word is written on the cycle after its final lane handshake, if the FIFO is not full.
//   Minimum cost is LANES+1 cycles per full word, or LANES+2 when the word closes a packet.
// - res_last on lane 0 produces a word holding a single lane. A full word whose lane LANES-1 carries res_last writes once.
// - words_written is 16-bit modulo: 0xFFFF + 1 -> 0x0000.
// - resetn asserted mid-fill or mid-stall: the partial word is discarded and no rq_we is issued.
//   After release, the block restarts at lane 0.
// - res_data and res_last are don't-care when res_valid=0.
//
// TESTING
// 1. rq_full=0; send 0x11,0x22,0x33,0x44 back-to-back.
//    -> exactly one rq_we, rq_data=0x44332211, 1 cycle after the 4th handshake; words_written=1; packet_done=0.
// 2. Send 0xAA, then 0xBB with res_last=1.
//    -> rq_we with rq_data=0x0000BBAA; packet_done pulses the following cycle; then res_ready=1 again.
// 3. Fill one word while rq_full=1 for 5 cycles.
//    -> rq_we=0 and res_ready=0 throughout, rq_data stable; rq_we=1 on the first cycle rq_full=0.
// 4. Two lanes accepted, then resetn pulsed low mid-cycle.
//    -> outputs 0 immediately, no write; next word = 4 fresh lanes only.
// 5. Force words_written to 0xFFFF (65535 writes), write one more word.
//    -> words_written=0x0000.
// 6. res_valid toggled randomly against rq_full toggling, 1000 results, random res_last.
//    -> scoreboard: FIFO contents match packed stream, zero padding correct, rq_we never coincides with rq_full.

Source files
------------

// File: rtl/result_queue_loader.sv
// Producer-side stage of the result queue: packs LANES narrow results little-endian
// into one queue word and writes it to the result FIFO, honouring its full flag.
module result_queue_loader #(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8,
    parameter int LANES  = WIDTH / LANE_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [LANE_W-1:0] res_data,
    input  logic              res_last,
    input  logic              rq_full,
    output logic              rq_we,
    output logic [WIDTH-1:0]  rq_data,
    output logic              packet_done,
    output logic [15:0]       words_written
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_Reset = 2'd0,
        S_Fill  = 2'd1,
        S_Write = 2'd2,
        S_Done  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              last_q, last_d;
    logic [15:0]       words_q, words_d;

    logic handshake;
    logic closeWord;

    assign handshake = res_valid && (state_q == S_Fill);
    assign closeWord = handshake && ((idx_q == LAST_IDX) || res_last);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_Reset;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: a reset mid-fill simply drops the partial word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q   <= '0;
            acc_q   <= '0;
            last_q  <= 1'b0;
            words_q <= '0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_Reset: state_d = S_Fill;
            S_Fill:  if (closeWord) state_d = S_Write;
            S_Write: if (!rq_full) state_d = last_q ? S_Done : S_Fill;
            S_Done:  state_d = S_Fill;
            default: state_d = S_Reset;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        last_d  = last_q;
        words_d = words_q;
        case (state_q)
            S_Fill: begin
                if (handshake) begin
                    acc_d[int'(idx_q)*LANE_W +: LANE_W] = res_data;
                    if (closeWord) begin
                        last_d = res_last;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_Write: begin
                // Clearing acc here is what keeps unfilled upper lanes of the next word at zero.
                if (!rq_full) begin
                    words_d = words_q + 16'd1;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            S_Done:  last_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        res_ready     = (state_q == S_Fill);
        rq_we         = (state_q == S_Write) && !rq_full;
        packet_done   = (state_q == S_Done);
        rq_data       = acc_q;
        words_written = words_q;
    end

endmodule

// File: tb/tb_result_queue_loader.sv
// Self-checking bench for result_queue_loader: directed scenarios plus a randomized
// stream, all checked against a lane-packing reference model.
module tb_result_queue_loader;

    localparam int WIDTH  = 32;
    localparam int LANE_W = 8;
    localparam int LANES  = WIDTH / LANE_W;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              res_valid = 1'b0;
    logic              res_ready;
    logic [LANE_W-1:0] res_data = '0;
    logic              res_last = 1'b0;
    logic              rq_full = 1'b0;
    logic              rq_we;
    logic [WIDTH-1:0]  rq_data;
    logic              packet_done;
    logic [15:0]       words_written;

    result_queue_loader #(.WIDTH(WIDTH), .LANE_W(LANE_W), .LANES(LANES)) dut (
        .clk(clk),
        .resetn(resetn),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_last(res_last),
        .rq_full(rq_full),
        .rq_we(rq_we),
        .rq_data(rq_data),
        .packet_done(packet_done),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int vectorCount = 0;
    int errorCount  = 0;

    // Reference model: a word under construction plus at most one closed word awaiting the FIFO.
    logic [WIDTH-1:0] curWord;
    int               curLanes;
    bit               pendWord;
    logic [WIDTH-1:0] pendData;
    bit               pendLast;
    bit               doneDue;
    bit               startup;
    logic [15:0]      expWords;
    int               accepted = 0;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                               input logic [WIDTH-1:0] exp);
        vectorCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        curWord  = '0;
        curLanes = 0;
        pendWord = 1'b0;
        pendData = '0;
        pendLast = 1'b0;
        doneDue  = 1'b0;
        startup  = 1'b1;
        expWords = '0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic applyStimulus(input bit v, input logic [LANE_W-1:0] d, input bit l, input bit f);
        bit expReady;
        bit expWe;
        bit newDone;
        @(negedge clk);
        res_valid = v;
        res_data  = d;
        res_last  = l;
        rq_full   = f;
        #1;
        expReady = !startup && !pendWord && !doneDue;
        expWe    = pendWord && !f;
        checkOutput("res_ready", WIDTH'(res_ready), WIDTH'(expReady));
        checkOutput("rq_we", WIDTH'(rq_we), WIDTH'(expWe));
        checkOutput("we_while_full", WIDTH'(rq_we & rq_full), '0);
        if (pendWord) checkOutput("rq_data", rq_data, pendData);
        checkOutput("packet_done", WIDTH'(packet_done), WIDTH'(doneDue));
        checkOutput("words_written", WIDTH'(words_written), WIDTH'(expWords));
        newDone = 1'b0;
        if (expWe) begin
            expWords = expWords + 16'd1;
            pendWord = 1'b0;
            newDone  = pendLast;
        end
        if (expReady && v) begin
            curWord = curWord | (WIDTH'(d) << (LANE_W * curLanes));
            curLanes++;
            accepted++;
            if (curLanes == LANES || l) begin
                pendWord = 1'b1;
                pendData = curWord;
                pendLast = l;
                curWord  = '0;
                curLanes = 0;
            end
        end
        doneDue = newDone;
        startup = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, WIDTH'(res_ready), '0);
        checkOutput({tag, "_we"}, WIDTH'(rq_we), '0);
        checkOutput({tag, "_data"}, rq_data, '0);
        checkOutput({tag, "_done"}, WIDTH'(packet_done), '0);
        checkOutput({tag, "_words"}, WIDTH'(words_written), '0);
    endtask

    initial begin
        int startCount;
        int cycles;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Four back-to-back lanes form one word, written one cycle later
        applyStimulus(0, '0, 0, 0);
        applyStimulus(1, 8'h11, 0, 0);
        applyStimulus(1, 8'h22, 0, 0);
        applyStimulus(1, 8'h33, 0, 0);
        applyStimulus(1, 8'h44, 0, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("t1_we", WIDTH'(rq_we), 1);
        checkOutput("t1_data", rq_data, 32'h44332211);
        applyStimulus(0, '0, 0, 0);
        checkOutput("t1_words", WIDTH'(words_written), 1);
        checkOutput("t1_done", WIDTH'(packet_done), 0);

        // Early close by res_last, then packet_done
        applyStimulus(1, 8'hAA, 0, 0);
        applyStimulus(1, 8'hBB, 1, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("t2_data", rq_data, 32'h0000BBAA);
        applyStimulus(0, '0, 0, 0);
        checkOutput("t2_done", WIDTH'(packet_done), 1);
        applyStimulus(0, '0, 0, 0);
        checkOutput("t2_ready", WIDTH'(res_ready), 1);

        // Single-lane packet
        applyStimulus(1, 8'h5C, 1, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("lane0_last", rq_data, 32'h0000005C);
        applyStimulus(0, '0, 0, 0);
        applyStimulus(0, '0, 0, 0);

        // FIFO full for five cycles after the word closes
        for (int i = 0; i < LANES; i++) applyStimulus(1, LANE_W'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'hEE, 0, 1);
        applyStimulus(0, '0, 0, 0);
        checkOutput("t3_we", WIDTH'(rq_we), 1);
        checkOutput("t3_data", rq_data, 32'hC3C2C1C0);
        applyStimulus(0, '0, 0, 0);

        // Reset mid-fill discards the partial word
        applyStimulus(1, 8'h01, 0, 0);
        applyStimulus(1, 8'h02, 0, 0);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkResetOutputs("midreset");
        modelReset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        applyStimulus(0, '0, 0, 0);
        for (int i = 0; i < LANES; i++) applyStimulus(1, LANE_W'(8'h90 + i), 0, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("t4_data", rq_data, 32'h93929190);
        applyStimulus(0, '0, 0, 0);

        // Word counter wrap
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        force dut.words_q = 16'hFFFF;
        #1;
        release dut.words_q;
        expWords = 16'hFFFF;
        for (int i = 0; i < LANES; i++) applyStimulus(1, LANE_W'($urandom), 0, 0);
        applyStimulus(0, '0, 0, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("wrap", WIDTH'(words_written), '0);

        // Randomized stream against a toggling full flag
        startCount = accepted;
        cycles = 0;
        while ((accepted - startCount) < 1000 && cycles < 20000) begin
            applyStimulus($urandom_range(0, 3) != 0, LANE_W'($urandom),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
            cycles++;
        end
        checkOutput("random_budget", WIDTH'((accepted - startCount) >= 1000), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
